key_event_decoder: RTL

Parametrised PS/2 key-event decoder that turns the keyboard driver's current scan code into per-key, single-cycle press pulses for game control logic (left/right/select/start and beyond). It generalises our fixed four-key press detector to NUM_KEYS channels with a runtime code map, a stability filter, and per-key typematic auto-repeat. It sits between keyboard_driver and the game FSM, in the game clock domain.

---
 rtl/key_event_pkg.sv | 20 ++
 rtl/key_event_decoder_if.sv | 26 ++
 rtl/key_event_channel.sv | 109 ++++++++++
 rtl/key_event_decoder.sv | 78 +++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event decoder and its per-key channels.
`timescale 1ns/1ps
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HELD   = 2'd2,
    REPEAT = 2'd3
  } key_state_e;

  localparam int CODE_NONE = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Scan-code inputs and key-event outputs of the decoder; master drives codes, slave decodes.
`timescale 1ns/1ps
interface key_event_decoder_if #(
  parameter int NUM_KEYS = 4,
  parameter int CODE_W   = 8
);
  localparam int LK_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [CODE_W-1:0]          i_code;
  logic [NUM_KEYS*CODE_W-1:0] i_key_codes;
  logic [NUM_KEYS-1:0]        i_repeat_en;
  logic [NUM_KEYS-1:0]        o_press;
  logic [NUM_KEYS-1:0]        o_held;
  logic [LK_W-1:0]            o_last_key;
  logic                       o_last_valid;

  modport master (
    output i_code, i_key_codes, i_repeat_en,
    input  o_press, o_held, o_last_key, o_last_valid
  );

  modport slave (
    input  i_code, i_key_codes, i_repeat_en,
    output o_press, o_held, o_last_key, o_last_valid
  );
endinterface

// File: rtl/key_event_channel.sv
// One key channel: stability filter, press pulse and typematic repeat; pulse is registered,
// o_fire is the same decision one cycle early for the top-level last-key register.
`timescale 1ns/1ps
module key_event_channel
  import key_event_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int HOLD_DELAY    = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_match,
  input  logic i_repeat_en,
  output logic o_fire,
  output logic o_press,
  output logic o_held
);
  localparam int CNT_W = $clog2(max3(STABLE_CYCLES, HOLD_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'(REPEAT_PERIOD - 1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, held_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_match) begin
          if (STABLE_CYCLES == 1) begin
            state_d = HELD;
            cnt_d   = '0;
            o_fire  = 1'b1;
          end else begin
            state_d = ARM;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ARM: begin
        if (!i_match) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          o_fire  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!i_match) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          // Without repeat the counter parks here until repeat is enabled or the key released.
          if (i_repeat_en) begin
            state_d = REPEAT;
            cnt_d   = '0;
            o_fire  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!i_match) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!i_repeat_en) begin
          state_d = HELD;
          cnt_d   = HOLD_LAST;
        end else if (cnt_q == REP_LAST) begin
          cnt_d  = '0;
          o_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= o_fire;
      held_q  <= (state_d == HELD) || (state_d == REPEAT);
    end
  end

  assign o_press = press_q;
  assign o_held  = held_q;
endmodule

// File: rtl/key_event_decoder.sv
// Maps the held scan code to per-key press/repeat pulses via NUM_KEYS channels; all outputs registered,
// first press STABLE_CYCLES samples after the code appears; no backpressure, pulses are fire-and-forget.
`timescale 1ns/1ps
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int CODE_W        = 8,
  parameter int STABLE_CYCLES = 2,
  parameter int HOLD_DELAY    = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  key_event_decoder_if.slave bus
);
  localparam int LK_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [NUM_KEYS-1:0] grant, fire, press, held;
  logic [CODE_W-1:0]   code_k;
  logic                found;
  logic [LK_W-1:0]     fire_idx;
  logic [LK_W-1:0]     last_key_q;
  logic                last_valid_q;

  // Duplicate map entries: only the lowest matching channel sees the key.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    code_k = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      code_k = bus.i_key_codes[k*CODE_W +: CODE_W];
      if (!found && (bus.i_code != CODE_W'(CODE_NONE)) && (bus.i_code == code_k) &&
          (code_k != CODE_W'(CODE_NONE))) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_event_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_DELAY   (HOLD_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_match    (grant[k]),
      .i_repeat_en(bus.i_repeat_en[k]),
      .o_fire     (fire[k]),
      .o_press    (press[k]),
      .o_held     (held[k])
    );
  end

  always_comb begin
    fire_idx = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (fire[k]) fire_idx = LK_W'(k);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_key_q   <= '0;
      last_valid_q <= 1'b0;
    end else if (|fire) begin
      last_key_q   <= fire_idx;
      last_valid_q <= 1'b1;
    end
  end

  assign bus.o_press      = press;
  assign bus.o_held       = held;
  assign bus.o_last_key   = last_key_q;
  assign bus.o_last_valid = last_valid_q;
endmodule
